sort_result_reader: RTL and testbench

Read-back engine for the bubble-sort memory. After the sorter asserts Finish, this block reads the element count from the size word, fetches the sorted array from address 0 upward, and presents each element on a valid/ready output stream. It checks ascending signed order on the fly and reports the first violation. It sits on the memory read port that the sorter releases when it finishes, and feeds the downstream result consumer.

---
 rtl/sort_result_reader_pkg.sv | 16 +
 rtl/sort_result_reader_order_checker.sv | 48 ++++
 rtl/sort_result_reader.sv | 148 ++++++++++++++
 tb/tb_sort_result_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_result_reader_pkg.sv
// Shared constants and state encoding for the bubble-sort result read-back path.
package sort_result_reader_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned SIZE_ADDR  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_SIZE = 3'd1,
    ST_READ    = 3'd2,
    ST_OUT     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage : sort_result_reader_pkg

// File: rtl/sort_result_reader_order_checker.sv
// Tracks the previously captured element and flags the first descending step.
//   clk, rst   : clock, async active-low reset
//   clear      : wipe prev and the sticky error at the start of a read-back
//   sample     : data/idx are a freshly read element
//   idx, data  : element index and value (signed)
//   error      : sticky order-violation flag
//   err_idx    : index of the first violating element
module sort_result_reader_order_checker
  import sort_result_reader_pkg::*;
#(
  parameter int unsigned dataWidth = DATA_WIDTH,
  parameter int unsigned addrWidth = ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [addrWidth-1:0] idx,
  input  logic [dataWidth-1:0] data,
  output logic                 error,
  output logic [addrWidth-1:0] err_idx
);

  logic [dataWidth-1:0] prev_q;
  logic                 descend_c;

  // Element 0 has no predecessor; equal neighbours are legal.
  assign descend_c = (idx != '0) && ($signed(data) < $signed(prev_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= '0;
      error   <= 1'b0;
      err_idx <= '0;
    end else if (clear) begin
      prev_q  <= '0;
      error   <= 1'b0;
      err_idx <= '0;
    end else if (sample) begin
      prev_q <= data;
      if (descend_c && !error) begin
        error   <= 1'b1;
        err_idx <= idx;
      end
    end
  end

endmodule : sort_result_reader_order_checker

// File: rtl/sort_result_reader.sv
// Reads the element count and the sorted array back from the sorter memory and
// streams the elements on a valid/ready port while checking ascending order.
//   clk, rst          : clock, async active-low reset
//   Start             : begin a read-back (honoured only in IDLE)
//   RAddr / RData     : memory read port (registered address, same-cycle data)
//   OData/OValid/OLast: output stream, OReady is the downstream accept
//   Done              : one-cycle end-of-read-back pulse
//   Error / ErrIdx    : sticky first order violation and its element index
module sort_result_reader
  import sort_result_reader_pkg::*;
#(
  parameter int unsigned dataWidth = DATA_WIDTH,
  parameter int unsigned addrWidth = ADDR_WIDTH,
  parameter int unsigned sizeAddr  = SIZE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  output logic [addrWidth-1:0] RAddr,
  input  logic [dataWidth-1:0] RData,
  output logic [dataWidth-1:0] OData,
  output logic                 OValid,
  input  logic                 OReady,
  output logic                 OLast,
  output logic                 Done,
  output logic                 Error,
  output logic [addrWidth-1:0] ErrIdx
);

  localparam logic signed [dataWidth-1:0] SIZE_LIM = dataWidth'(sizeAddr);

  state_t               state_q, state_d;
  logic [addrWidth-1:0] raddr_d;
  logic [dataWidth-1:0] odata_d;
  logic                 ovalid_d, olast_d;
  logic [addrWidth-1:0] size_q, size_d;
  logic [addrWidth-1:0] idx_q, idx_d;
  logic                 sample_c, clear_c;
  logic signed [dataWidth-1:0] rdata_s;

  assign rdata_s = RData;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      RAddr   <= '0;
      OData   <= '0;
      OValid  <= 1'b0;
      OLast   <= 1'b0;
      Done    <= 1'b0;
      size_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      RAddr   <= raddr_d;
      OData   <= odata_d;
      OValid  <= ovalid_d;
      OLast   <= olast_d;
      // Done mirrors the DONE state so a Start during the pulse is ignored.
      Done    <= (state_d == ST_DONE);
      size_q  <= size_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    raddr_d  = RAddr;
    odata_d  = OData;
    ovalid_d = OValid;
    olast_d  = OLast;
    size_d   = size_q;
    idx_d    = idx_q;
    sample_c = 1'b0;
    clear_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RD_SIZE;
          raddr_d = addrWidth'(sizeAddr);
          clear_c = 1'b1;
        end
      end

      ST_RD_SIZE: begin
        size_d = RData[addrWidth-1:0];
        if (RData[dataWidth-1] || (RData == '0)) begin
          state_d = ST_DONE;
        end else begin
          if (rdata_s > SIZE_LIM) begin
            size_d = addrWidth'(sizeAddr);
          end
          idx_d   = '0;
          raddr_d = '0;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        odata_d  = RData;
        ovalid_d = 1'b1;
        olast_d  = (idx_q == (size_q - addrWidth'(1)));
        sample_c = 1'b1;
        state_d  = ST_OUT;
      end

      ST_OUT: begin
        if (OReady) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          if (OLast) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + addrWidth'(1);
            raddr_d = idx_q + addrWidth'(1);
            state_d = ST_READ;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  sort_result_reader_order_checker #(
    .dataWidth (dataWidth),
    .addrWidth (addrWidth)
  ) u_order_checker (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_c),
    .sample  (sample_c),
    .idx     (idx_q),
    .data    (RData),
    .error   (Error),
    .err_idx (ErrIdx)
  );

endmodule : sort_result_reader

// File: tb/tb_sort_result_reader.sv
// Scoreboard bench: expected elements are queued when a read-back is launched
// and popped as the DUT hands each one over.
module tb_sort_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Start = 1'b0;
  logic        OReady = 1'b0;
  logic [9:0]  RAddr;
  logic [31:0] RData;
  logic [31:0] OData;
  logic        OValid;
  logic        OLast;
  logic        Done;
  logic        Error;
  logic [9:0]  ErrIdx;

  logic signed [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic [9:0]  idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  assign RData = mem[RAddr];

  sort_result_reader dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .RAddr  (RAddr),
    .RData  (RData),
    .OData  (OData),
    .OValid (OValid),
    .OReady (OReady),
    .OLast  (OLast),
    .Done   (Done),
    .Error  (Error),
    .ErrIdx (ErrIdx)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic load_sorted();
    mem[0] = -7; mem[1] = -2; mem[2] = 0; mem[3] = 3; mem[4] = 9;
  endtask

  // One read-back: Start issued in cycle 0, outputs sampled on the falling edge.
  task automatic run(input int size_word, input int stall_elem, input int stall_len);
    int   n, exp_done, cyc, done_cyc, acc, stall_left, budget, exp_erridx, stall_used;
    bit   got_done, exp_error;
    exp_t e;

    mem[1023] = size_word;
    n = (size_word <= 0) ? 0 : ((size_word > 1023) ? 1023 : size_word);
    q.delete();
    for (int i = 0; i < n; i++) begin
      e.d    = mem[i];
      e.last = (i == n - 1);
      e.idx  = 10'(i);
      q.push_back(e);
    end
    exp_error  = 1'b0;
    exp_erridx = 0;
    for (int i = 1; i < n; i++) begin
      if (!exp_error && (mem[i] < mem[i-1])) begin
        exp_error  = 1'b1;
        exp_erridx = i;
      end
    end
    stall_used = (stall_elem >= 0 && stall_elem < n) ? stall_len : 0;
    exp_done   = (n == 0) ? 2 : (2 * n + 2 + stall_used);
    budget     = exp_done + 20;

    got_done   = 1'b0;
    done_cyc   = -1;
    acc        = 0;
    stall_left = stall_len;

    Start  = 1'b1;
    OReady = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    cyc   = 1;
    while (cyc <= budget && !got_done) begin
      if (OValid && acc == stall_elem && stall_left > 0) begin
        OReady = 1'b0;
        stall_left--;
      end else begin
        OReady = 1'b1;
      end
      @(negedge clk);
      if (Done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
      if (OValid) begin
        if (q.size() == 0) begin
          chk("spurious_ovalid", 64'(OValid), 64'd0);
        end else begin
          e = q[0];
          chk("odata", 64'(OData), 64'(e.d));
          chk("olast", 64'(OLast), 64'(e.last));
          if (OReady) begin
            chk("raddr", 64'(RAddr), 64'(e.idx));
            void'(q.pop_front());
            acc++;
          end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    OReady = 1'b1;
    chk("done_seen", 64'(got_done), 64'd1);
    if (got_done) chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("all_emitted", 64'(q.size()), 64'd0);
    chk("error", 64'(Error), 64'(exp_error));
    chk("err_idx", 64'(ErrIdx), 64'(exp_erridx));
  endtask

  task automatic reset_in_out();
    bit seen;
    load_sorted();
    mem[1023] = 5;
    Start  = 1'b1;
    OReady = 1'b0;
    @(posedge clk);
    #1;
    Start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = OValid;
    end
    chk("reached_out", 64'(seen), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_raddr", 64'(RAddr), 64'd0);
    chk("rst_odata", 64'(OData), 64'd0);
    chk("rst_ovalid", 64'(OValid), 64'd0);
    chk("rst_olast", 64'(OLast), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_error", 64'(Error), 64'd0);
    chk("rst_erridx", 64'(ErrIdx), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", 64'(Done), 64'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(Done), 64'd0);
    OReady = 1'b1;
    run(5, -1, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    load_sorted();
    mem[1023] = 5;

    #12;
    chk("init_raddr", 64'(RAddr), 64'd0);
    chk("init_ovalid", 64'(OValid), 64'd0);
    chk("init_done", 64'(Done), 64'd0);
    chk("init_error", 64'(Error), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run(5, -1, 0);                                   // sorted, no stall
    @(posedge clk); #1;
    run(5, 2, 3);                                    // 3-cycle stall on element 2
    @(posedge clk); #1;
    mem[0] = 1; mem[1] = 5; mem[2] = 2; mem[3] = 3;
    run(4, -1, 0);                                   // violation at idx 2
    @(posedge clk); #1;
    load_sorted();
    run(5, -1, 0);                                   // Start clears Error
    @(posedge clk); #1;
    run(0, -1, 0);
    @(posedge clk); #1;
    run(-1, -1, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 1023; i++) mem[i] = i;
    run(2000, -1, 0);                                // clamp to 1023
    @(posedge clk); #1;
    mem[0] = 1; mem[1] = 5; mem[2] = 2; mem[3] = 3;
    run(4, -1, 0);                                   // leave Error set
    @(posedge clk); #1;
    reset_in_out();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_sort_result_reader
